// File: rtl/conv_layer_stream.sv
// conv_layer_stream: streaming conv layer with a single serial MAC.
// Weights and one frame of pixels are buffered in internal memories. Each output
// (filter-major, then row-major) takes FILTER_SIZE^2 products and is then scaled,
// saturated and optionally rectified. Weights survive across frames until reset.
module conv_layer_stream #(
  parameter int NUM_FILTERS = 16,
  parameter int INPUT_SIZE  = 28,
  parameter int FILTER_SIZE = 7,
  parameter int STRIDE      = 2,
  parameter int DATA_W      = 32,
  parameter int ACC_W       = 72,
  parameter int FRAC_BITS   = 16,
  parameter int RELU_EN     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wt_valid,
  input  logic [DATA_W-1:0] wt_data,
  output logic              wt_ready,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [(NUM_FILTERS > 1 ? $clog2(NUM_FILTERS) : 1)-1:0] out_filter,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy
);
  localparam int K2       = FILTER_SIZE * FILTER_SIZE;
  localparam int NPX      = INPUT_SIZE * INPUT_SIZE;
  localparam int NWT      = NUM_FILTERS * K2;
  localparam int OUT_SIZE = (INPUT_SIZE - FILTER_SIZE) / STRIDE + 1;
  localparam int FW  = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int OW  = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int KW  = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
  localparam int TW  = $clog2(K2 + 1);
  localparam int WCW = $clog2(NWT + 1);
  localparam int PCW = $clog2(NPX + 1);
  localparam int WAW = (NWT > 1) ? $clog2(NWT) : 1;
  localparam int PAW = (NPX > 1) ? $clog2(NPX) : 1;

  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]     state;
  logic [WCW-1:0] wt_cnt;
  logic [PCW-1:0] px_cnt;
  logic [FW-1:0]  f_cnt;
  logic [OW-1:0]  oy, ox;
  logic [KW-1:0]  ky, kx;
  logic [TW-1:0]  tap;
  logic [0:0]     vld_pipe;   // product of registered memory reads is valid

  logic [DATA_W-1:0] wmem [NWT];
  logic [DATA_W-1:0] pmem [NPX];
  logic signed [DATA_W-1:0] w_q, p_q;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc, acc_nxt, sh;
  logic signed [DATA_W-1:0]   res;
  logic [WAW-1:0] w_addr;
  logic [PAW-1:0] p_addr;
  logic wt_fire, in_fire, rd_issue, is_last;

  assign wt_ready = (state == S_LOAD) && (wt_cnt < WCW'(NWT));
  assign in_ready = (state == S_LOAD) && (px_cnt < PCW'(NPX));
  assign busy     = (state != S_LOAD);
  assign wt_fire  = wt_valid && wt_ready;
  assign in_fire  = in_valid && in_ready;
  assign rd_issue = (state == S_MAC) && (tap < TW'(K2));
  assign is_last  = (f_cnt == FW'(NUM_FILTERS-1)) && (oy == OW'(OUT_SIZE-1)) &&
                    (ox == OW'(OUT_SIZE-1));

  // Tap addresses for the current window position and kernel offset
  always_comb begin
    w_addr = WAW'(32'(f_cnt) * K2 + 32'(ky) * FILTER_SIZE + 32'(kx));
    p_addr = PAW'((32'(oy) * STRIDE + 32'(ky)) * INPUT_SIZE + 32'(ox) * STRIDE + 32'(kx));
  end

  // Accumulate, then shift, saturate and rectify the finished sum
  always_comb begin
    prod    = w_q * p_q;
    acc_nxt = ((tap == '0) ? '0 : acc) +
              (vld_pipe[0] ? {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod} : '0);
    sh      = acc_nxt >>> FRAC_BITS;
    if (sh > MAXV)      res = MAXV[DATA_W-1:0];
    else if (sh < MINV) res = MINV[DATA_W-1:0];
    else                res = sh[DATA_W-1:0];
    if (RELU_EN != 0 && res[DATA_W-1]) res = '0;
  end

  // Buffer memories and their registered read ports (contents survive reset)
  always_ff @(posedge clk) begin
    if (wt_fire) wmem[wt_cnt[WAW-1:0]] <= wt_data;
    if (in_fire) pmem[px_cnt[PAW-1:0]] <= in_data;
    w_q <= wmem[w_addr];
    p_q <= pmem[p_addr];
  end

  // Load / MAC / output sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_LOAD;
      wt_cnt     <= '0;
      px_cnt     <= '0;
      f_cnt      <= '0;
      oy         <= '0;
      ox         <= '0;
      ky         <= '0;
      kx         <= '0;
      tap        <= '0;
      acc        <= '0;
      vld_pipe   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_filter <= '0;
      out_last   <= 1'b0;
    end else begin
      vld_pipe[0] <= rd_issue;
      if (wt_fire) wt_cnt <= wt_cnt + WCW'(1);
      if (in_fire) px_cnt <= px_cnt + PCW'(1);
      case (state)
        S_LOAD: begin
          if (wt_cnt == WCW'(NWT) && px_cnt == PCW'(NPX)) begin
            state <= S_MAC;
            tap   <= '0;
          end
        end
        S_MAC: begin
          acc <= acc_nxt;
          if (rd_issue) begin
            if (kx == KW'(FILTER_SIZE-1)) begin
              kx <= '0;
              ky <= (ky == KW'(FILTER_SIZE-1)) ? '0 : ky + KW'(1);
            end else begin
              kx <= kx + KW'(1);
            end
          end
          if (tap == TW'(K2)) begin
            state      <= S_OUT;
            tap        <= '0;
            out_valid  <= 1'b1;
            out_data   <= res;
            out_filter <= f_cnt;
            out_last   <= is_last;
          end else begin
            tap <= tap + TW'(1);
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (is_last) begin
              state  <= S_LOAD;
              px_cnt <= '0;
              f_cnt  <= '0;
              oy     <= '0;
              ox     <= '0;
            end else begin
              state <= S_MAC;
              if (ox == OW'(OUT_SIZE-1)) begin
                ox <= '0;
                if (oy == OW'(OUT_SIZE-1)) begin
                  oy    <= '0;
                  f_cnt <= f_cnt + FW'(1);
                end else begin
                  oy <= oy + OW'(1);
                end
              end else begin
                ox <= ox + OW'(1);
              end
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end
endmodule

// File: doc/conv_layer_stream.md
Name: conv_layer_stream

Overview:
- Time-multiplexed, streaming successor to the combinational conv layer. Output ordering matches it (filter-major, row-major within each filter).
- Buffers one INPUT_SIZE×INPUT_SIZE frame and NUM_FILTERS×FILTER_SIZE² weights in internal memories.
- Computes each output with a single serial MAC.
- Adds: valid/ready streams, fixed-point scaling with saturation, optional ReLU, weight retention across frames.

Parameters:
- NUM_FILTERS, 16, number of filters.
- INPUT_SIZE, 28, square input edge.
- FILTER_SIZE, 7, square kernel edge.
- STRIDE, 2, window step in both axes.
- DATA_W, 32, signed pixel, weight and output width.
- ACC_W, 72, signed accumulator width (≥ 2*DATA_W + clog2(FILTER_SIZE²)).
- FRAC_BITS, 16, arithmetic right shift applied to the accumulator before saturation.
- RELU_EN, 0, 1 clamps negative results to 0.
- OUT_SIZE is derived, not overridable: (INPUT_SIZE-FILTER_SIZE)/STRIDE+1, integer division.

Ports:
- clk, input, 1, single clock, rising edge.
- rst, input, 1, synchronous active-high reset.
- wt_valid, input, 1, weight beat valid.
- wt_data, input, DATA_W, signed weight. Order: filter-major, then kernel row-major.
- wt_ready, output, 1, weight beat accepted when wt_valid && wt_ready.
- in_valid, input, 1, pixel beat valid.
- in_data, input, DATA_W, signed pixel, row-major.
- in_ready, output, 1, pixel accepted when in_valid && in_ready.
- out_valid, output, 1, result valid.
- out_data, output, DATA_W, signed result.
- out_filter, output, clog2(NUM_FILTERS), filter index of out_data.
- out_last, output, 1, final output of the frame.
- out_ready, input, 1, downstream accept.
- busy, output, 1, high in S_MAC or S_OUT.

Behaviour:
- Reset (synchronous, active-high, one cycle):
  - Outputs on the next cycle: out_valid=0, out_data=0, out_filter=0, out_last=0, busy=0, wt_ready=1, in_ready=1.
  - All counters cleared; weight-loaded flag cleared; FSM goes to S_LOAD.
  - Memory contents are not cleared.
  - Reset mid-frame or mid-output abandons the frame; weights must be reloaded.
- S_LOAD:
  - wt_ready=1 while weight count < NUM_FILTERS*FILTER_SIZE²; in_ready=1 while pixel count < INPUT_SIZE².
  - Both ports may accept in the same cycle.
  - Excess beats are not accepted: ready stays low once the corresponding count is full.
  - Transitions to S_MAC on the edge where both counts are full.
- Weights persist after a frame completes. wt_ready stays 0 until the next rst. Later frames need only pixels.
- S_MAC, per output (f, oy, ox):
  - Accumulator cleared on entry.
  - One product per cycle: weight[f][ky][kx] * pixel[(oy*STRIDE+ky)*INPUT_SIZE + ox*STRIDE+kx], ky/kx row-major.
  - Memory reads are registered (1-cycle latency), so S_MAC lasts exactly FILTER_SIZE²+1 cycles.
- Result computation:
  - Product is full 2*DATA_W signed; accumulation is in ACC_W.
  - result = acc >>> FRAC_BITS (arithmetic).
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - If RELU_EN, negative results become 0.
  - Registered into out_data on entry to S_OUT.
- S_OUT:
  - out_valid=1; out_data, out_filter and out_last are held stable until out_ready.
  - On handshake, advance ox, then oy, then f, and return to S_MAC.
  - After the output with f=NUM_FILTERS-1, oy=ox=OUT_SIZE-1 (out_last=1): clear the pixel count and go to S_LOAD.
- Latency: with weights loaded and out_ready held high:
  - First out_valid rises FILTER_SIZE²+2 cycles after the edge that accepts the last pixel.
  - Subsequent outputs are FILTER_SIZE²+2 cycles apart.
- Pixels beyond the last full window (non-dividing stride) are stored but never read.
- No output is produced until both the weight and pixel loads are complete.

Test Plan:
- Basic frame. Config: NUM_FILTERS=2, INPUT_SIZE=4, FILTER_SIZE=2, STRIDE=2, DATA_W=32, FRAC_BITS=0. Stimulus: pixels 1..16; filter0 weights {1,1,1,1}; filter1 weights {1,0,0,-1}. Required outputs in order: 14, 22, 46, 54, -5, -5, -5, -5. out_filter = 0,0,0,0,1,1,1,1; out_last only on the 8th; first out_valid 6 cycles after the last pixel.
- ReLU. Same stimulus with RELU_EN=1 → filter1 outputs are four 0s; filter0 outputs unchanged.
- Saturation. Config: DATA_W=8, FRAC_BITS=0, all pixels 127.
  - All weights 127 → every output 127 (raw 64516).
  - All weights -128 → every output -128 (raw -65024).
- Backpressure and reload. Hold out_ready low 10 cycles on the 2nd output → out_valid stays 1 and out_data stays 22 throughout. Then send a second frame of 16 pixels with no weights → weights retained, correct outputs, wt_ready stays 0.
- Load corner cases.
  - Interleave wt/pixel beats on the same cycles → both accepted.
  - Offer a 17th pixel → in_ready=0, beat not consumed.
  - INPUT_SIZE=5, FILTER_SIZE=2, STRIDE=2 → exactly 4 outputs per filter; row/column 4 ignored.
- Reset mid-operation. Assert rst for 1 cycle during S_MAC of the 3rd output → next cycle out_valid=0, busy=0, wt_ready=1, in_ready=1. A full reload then reproduces the basic-frame outputs.
